// File: rtl/nios_ocimem_arbiter.sv
// Purpose: round-robin sharing of the single-port OCI debug RAM between the Avalon debug slave and the JTAG command path.
// Latency: request seen in IDLE at cycle N -> ram_cs at N+1 -> completion at N+2; next grant no earlier than N+3.
// Backpressure: Avalon held off by waitrequest (low only in its completing cycle); JTAG buffers one request, extras are dropped and flagged in jtag_ovf.
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_avs_*, o_avs_*                Avalon debug-slave side (level-sensitive read/write, waitrequest handshake)
//   i_jtag_*, o_jtag_*              JTAG command side (set_addr/req pulses, done pulse, read data, sticky overflow)
//   o_ram_*, i_ram_rdata            registered RAM macro interface; read data arrives the cycle after ram_cs
module nios_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_avs_address,
  input  logic              i_avs_read,
  input  logic              i_avs_write,
  input  logic [DATA_W-1:0] i_avs_writedata,
  output logic              o_avs_waitrequest,
  output logic [DATA_W-1:0] o_avs_readdata,
  input  logic              i_jtag_set_addr,
  input  logic [ADDR_W-1:0] i_jtag_addr_in,
  input  logic              i_jtag_req,
  input  logic              i_jtag_wr,
  input  logic [DATA_W-1:0] i_jtag_wdata,
  output logic              o_jtag_done,
  output logic [DATA_W-1:0] o_jtag_rdata,
  output logic              o_jtag_ovf,
  input  logic              i_jtag_ovf_clr,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic G_AV = 1'b0;
  localparam logic G_JT = 1'b1;

  state_t            r_state;
  logic              r_pend;
  logic              r_pwr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_last;
  logic              r_grant;
  logic              r_gwr;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ovf;
  logic              r_wait;
  logic              r_done;
  logic              r_ram_cs;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_jrdata;

  logic w_av_req;
  logic w_jt_cmpl;
  logic w_jt_drop;
  logic w_grant_jt;

  assign w_av_req  = i_avs_read | i_avs_write;
  assign w_jt_cmpl = (r_state == S_RESP) && (r_grant == G_JT);
  // A request arriving in the completing cycle replaces the finishing one instead of overflowing.
  assign w_jt_drop = i_jtag_req && r_pend && !w_jt_cmpl;
  // Contention goes to the side that was not served last.
  assign w_grant_jt = r_pend && (!w_av_req || (r_last == G_AV));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_last      <= G_JT;
      r_grant     <= G_AV;
      r_gwr       <= 1'b0;
      r_wait      <= 1'b1;
      r_done      <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_jrdata    <= '0;
    end else begin
      r_done <= 1'b0;
      r_wait <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_av_req || r_pend) begin
            r_state  <= S_ACC;
            r_grant  <= w_grant_jt;
            r_ram_cs <= 1'b1;
            if (w_grant_jt) begin
              r_ram_we    <= r_pwr;
              r_gwr       <= r_pwr;
              r_ram_addr  <= r_ptr;
              r_ram_wdata <= r_pwdata;
            end else begin
              // read and write together behave as a write
              r_ram_we    <= i_avs_write;
              r_gwr       <= i_avs_write;
              r_ram_addr  <= i_avs_address;
              r_ram_wdata <= i_avs_writedata;
            end
          end
        end
        S_ACC: begin
          r_state  <= S_RESP;
          r_ram_cs <= 1'b0;
          r_ram_we <= 1'b0;
          // completion strobes are registered so they line up with RESP
          r_wait   <= (r_grant != G_AV);
          r_done   <= (r_grant == G_JT);
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_last  <= r_grant;
          if ((r_grant == G_JT) && !r_gwr) begin
            r_jrdata <= i_ram_rdata;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // JTAG request latch, overflow flag and address pointer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend   <= 1'b0;
      r_pwr    <= 1'b0;
      r_pwdata <= '0;
      r_ovf    <= 1'b0;
      r_ptr    <= '0;
    end else begin
      if (i_jtag_req && !w_jt_drop) begin
        r_pend   <= 1'b1;
        r_pwr    <= i_jtag_wr;
        r_pwdata <= i_jtag_wdata;
      end else if (w_jt_cmpl) begin
        r_pend <= 1'b0;
      end

      if (w_jt_drop) begin
        r_ovf <= 1'b1;
      end else if (i_jtag_ovf_clr) begin
        r_ovf <= 1'b0;
      end

      // a load in the completing cycle wins; the finished access already used the old value
      if (i_jtag_set_addr) begin
        r_ptr <= i_jtag_addr_in;
      end else if (w_jt_cmpl) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end

  assign o_avs_waitrequest = r_wait;
  assign o_avs_readdata    = r_wait ? '0 : i_ram_rdata;
  assign o_jtag_done       = r_done;
  assign o_jtag_rdata      = r_jrdata;
  assign o_jtag_ovf        = r_ovf;
  assign o_ram_cs          = r_ram_cs;
  assign o_ram_we          = r_ram_we;
  assign o_ram_addr        = r_ram_addr;
  assign o_ram_wdata       = r_ram_wdata;

endmodule
